alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 19 +
 rtl/alu_arbiter_if.sv | 33 +++
 rtl/alu_arbiter_rr_pick2.sv | 18 +
 rtl/alu_arbiter.sv | 115 +++++++++++
 tb/tb_alu_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared constants for the two-requester ALU arbiter: default data width,
// ALU opcode values and the arbiter FSM state encoding.
package alu_arbiter_pkg;

  localparam int W_DEF = 16;

  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles the requester handshakes, the captured result and the shared ALU
// connection of alu_arbiter.
//   slave  : arbiter side (samples requests and ALU result, drives grants,
//            dones, result/zero and ALU operands)
//   master : environment side (requesters plus the external ALU)
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int W = W_DEF
);
  logic         req0, req1;
  logic [2:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1;
  logic         done0, done1;
  logic [W-1:0] result;
  logic         zero;
  logic [W-1:0] alu_in1, alu_in2;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_out;
  logic         alu_z;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_out, alu_z,
    output gnt0, gnt1, done0, done1, result, zero, alu_in1, alu_in2, alu_op
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_out, alu_z,
    input  gnt0, gnt1, done0, done1, result, zero, alu_in1, alu_in2, alu_op
  );
endinterface

// File: rtl/alu_arbiter_rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin pick.
//   req0_i, req1_i : request pair
//   last_i         : requester served last (0/1)
//   valid_o        : at least one request present
//   pick_o         : winning requester (0/1)
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic valid_o,
  output logic pick_o
);
  assign valid_o = req0_i | req1_i;
  // On a tie the requester that was not served last wins; otherwise the
  // single requester wins outright.
  assign pick_o  = (req0_i & req1_i) ? ~last_i : req1_i;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external, pipelined ALU between two requesters with
// round-robin arbitration.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_arbiter_if.slave (requests, grants, dones,
//                result/zero, ALU operands and ALU result)
// Parameters: W data width, ALU_LAT clock edges from ALU operands to
// alu_out/alu_z valid (>= 1).
//
// state   | meaning
// IDLE    | ALU operands at NOP/0, waiting for a request
// ISSUE   | operands of the winner presented, grant pulse high
// WAIT    | counting ALU latency down to terminal count
// CAPTURE | ALU output valid, latched into result/zero on exit
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  arb_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic         last_q;
  logic         owner_q;
  logic         gnt0_q, gnt1_q, done0_q, done1_q;
  logic [W-1:0] result_q;
  logic         zero_q;
  logic [W-1:0] alu_in1_q, alu_in2_q;
  logic [2:0]   alu_op_q;

  logic         pick_valid;
  logic         pick;

  rr_pick2 u_pick (
    .req0_i  (bus.req0),
    .req1_i  (bus.req1),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .pick_o  (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      alu_op_q  <= ALU_NOP;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            owner_q   <= pick;
            last_q    <= pick;
            gnt0_q    <= ~pick;
            gnt1_q    <= pick;
            alu_op_q  <= pick ? bus.op1 : bus.op0;
            alu_in1_q <= pick ? bus.a1  : bus.a0;
            alu_in2_q <= pick ? bus.b1  : bus.b0;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= CW'(ALU_LAT - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_q <= ST_CAPTURE;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        ST_CAPTURE: begin
          result_q  <= bus.alu_out;
          zero_q    <= bus.alu_z;
          done0_q   <= ~owner_q;
          done1_q   <= owner_q;
          alu_op_q  <= ALU_NOP;
          alu_in1_q <= '0;
          alu_in2_q <= '0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.alu_in1 = alu_in1_q;
  assign bus.alu_in2 = alu_in2_q;
  assign bus.alu_op  = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W   = 16;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.W(W)) bus ();

  alu_arbiter #(.W(W), .ALU_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural ALU: result = f(op, a, b), zero = (result == 0)
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  // External ALU with one edge of latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_out <= '0;
      bus.alu_z   <= 1'b0;
    end else begin
      bus.alu_out <= alu_fn(bus.alu_op, bus.alu_in1, bus.alu_in2);
      bus.alu_z   <= (alu_fn(bus.alu_op, bus.alu_in1, bus.alu_in2) == '0);
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected result/zero per requester, pushed at request time
  logic [W-1:0] exp_r0[$], exp_r1[$];
  logic         exp_z0[$], exp_z1[$];
  int           gcyc[2];
  bit           gpend[2];
  bit           last_srv = 1'b1;
  logic [1:0]   req_snap = 2'b00;

  always @(posedge clk) req_snap <= {bus.req1, bus.req0};

  // Monitor
  bit mw, dw;
  logic [W-1:0] er;
  logic ez;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.gnt0 || bus.gnt1) begin
        check("gnt_onehot", 64'(bus.gnt0 && bus.gnt1), 64'd0);
        mw = bus.gnt1;
        check("gnt_had_req", 64'(req_snap[mw]), 64'd1);
        if (req_snap == 2'b11) check("rr_winner", 64'(mw), 64'(!last_srv));
        last_srv = mw;
        gcyc[mw] = cyc;
        gpend[mw] = 1'b1;
      end
      if (bus.done0 || bus.done1) begin
        check("done_onehot", 64'(bus.done0 && bus.done1), 64'd0);
        dw = bus.done1;
        check("done_after_gnt", 64'(gpend[dw]), 64'd1);
        if (gpend[dw]) check("done_latency", 64'(cyc - gcyc[dw]), 64'(LAT + 2));
        gpend[dw] = 1'b0;
        check("alu_idle_nop", {29'd0, bus.alu_op, bus.alu_in1, bus.alu_in2}, 64'd0);
        if ((dw ? exp_r1.size() : exp_r0.size()) == 0) begin
          check("done_expected", 64'd0, 64'd1);
        end else begin
          if (dw) begin er = exp_r1.pop_front(); ez = exp_z1.pop_front(); end
          else    begin er = exp_r0.pop_front(); ez = exp_z0.pop_front(); end
          check(dw ? "result1" : "result0", 64'(bus.result), 64'(er));
          check(dw ? "zero1" : "zero0", 64'(bus.zero), 64'(ez));
        end
      end
    end
  end

  // Requester driver: call at a negedge; returns the cycle the grant was seen
  task automatic issue(input int r, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit keep, output int gc);
    int n;
    logic [W-1:0] e;
    e = alu_fn(op, a, b);
    if (r == 1) begin
      bus.op1 = op; bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
      exp_r1.push_back(e); exp_z1.push_back(e == '0);
    end else begin
      bus.op0 = op; bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
      exp_r0.push_back(e); exp_z0.push_back(e == '0);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((r == 1) ? bus.gnt1 : bus.gnt0) && n < 60);
    gc = cyc;
    if (n >= 60) check("gnt_timeout", 64'd0, 64'd1);
    if (!keep) begin
      if (r == 1) bus.req1 = 1'b0;
      else        bus.req0 = 1'b0;
    end
  endtask

  task automatic flush_model();
    exp_r0.delete(); exp_r1.delete(); exp_z0.delete(); exp_z1.delete();
    gpend[0] = 1'b0; gpend[1] = 1'b0;
    last_srv = 1'b1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    flush_model();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return {7'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.zero,
            bus.result, bus.alu_op, bus.alu_in1, bus.alu_in2};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  int g0, g1, g2, g3;

  initial begin
    bus.req0 = 0; bus.req1 = 0;
    bus.op0 = 0; bus.op1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // single request on each side
    issue(0, ALU_ADD, 16'd2, 16'd4, 1'b0, g0);
    repeat (4) @(negedge clk);
    check("add_result", 64'(bus.result), 64'd6);
    check("add_zero", 64'(bus.zero), 64'd0);
    issue(1, ALU_SUB, 16'd5, 16'd5, 1'b0, g0);
    repeat (4) @(negedge clk);
    check("sub_result", 64'(bus.result), 64'd0);
    check("sub_zero", 64'(bus.zero), 64'd1);

    // simultaneous requests after reset: requester 0 first
    do_reset();
    fork
      issue(0, ALU_SUB, 16'd5, 16'd3, 1'b0, g0);
      issue(1, ALU_SUB, 16'd16, 16'd2, 1'b0, g1);
    join
    check("tie_order", 64'(g1 > g0), 64'd1);
    check("tie_spacing", 64'(g1 - g0), 64'(LAT + 3));
    repeat (4) @(negedge clk);
    check("tie_final_result", 64'(bus.result), 64'd14);

    // held request: back-to-back grants every LAT+3 cycles
    issue(0, ALU_ADD, 16'd1, 16'd1, 1'b1, g1);
    issue(0, ALU_SUB, 16'd9, 16'd9, 1'b1, g2);
    issue(0, ALU_ADD, 16'd3, 16'd3, 1'b0, g3);
    check("b2b_gap1", 64'(g2 - g1), 64'(LAT + 3));
    check("b2b_gap2", 64'(g3 - g2), 64'(LAT + 3));
    repeat (4) @(negedge clk);
    check("b2b_result", 64'(bus.result), 64'd6);

    // reset while waiting on the ALU
    issue(0, ALU_ADD, 16'd7, 16'd8, 1'b0, g0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort_outputs", all_outs(), 64'd0);
    flush_model();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_result_held", {47'd0, bus.zero, bus.result}, 64'd0);
    issue(1, ALU_ADD, 16'd3, 16'd4, 1'b0, g0);
    repeat (4) @(negedge clk);
    check("post_abort_result", 64'(bus.result), 64'd7);

    // randomized traffic from both requesters
    fork
      begin
        int gr;
        logic [W-1:0] a;
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 6)) @(negedge clk);
          a = W'($urandom);
          issue(0, 3'($urandom_range(0, 6)), a,
                ($urandom_range(0, 3) == 0) ? a : W'($urandom), 1'b0, gr);
        end
      end
      begin
        int gr;
        logic [W-1:0] a;
        for (int j = 0; j < 20; j++) begin
          repeat ($urandom_range(0, 6)) @(negedge clk);
          a = W'($urandom);
          issue(1, 3'($urandom_range(0, 6)), a,
                ($urandom_range(0, 3) == 0) ? a : W'($urandom), 1'b0, gr);
        end
      end
    join
    repeat (10) @(negedge clk);
    check("scoreboard_empty", 64'(exp_r0.size() + exp_r1.size()), 64'd0);
    check("final_idle_alu", {29'd0, bus.alu_op, bus.alu_in1, bus.alu_in2}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
